// File: rtl/contador_palabras_pkg.sv
// Shared constants and FSM encoding for the output-FIFO word-count monitor.
package contador_palabras_pkg;

  localparam int unsigned CNT_W     = 5;
  localparam int unsigned NUM_FIFOS = 4;

  // Counter index that selects the all-FIFO total.
  localparam logic [2:0] IDX_TOTAL = 3'd4;

  typedef enum logic {
    COUNT = 1'b0,
    READ  = 1'b1
  } state_t;

endpackage

// File: rtl/contador_unidad.sv
// Single wrap-around word counter with a small unsigned increment per cycle.
module contador_unidad #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Plain modular add: wraps to zero instead of saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(inc);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/contador_palabras.sv
// Counts words popped from each output FIFO plus a running total, and returns
// one selected counter per request while the main FSM is idle.
module contador_palabras #(
  parameter int unsigned CNT_W     = contador_palabras_pkg::CNT_W,
  parameter int unsigned NUM_FIFOS = contador_palabras_pkg::NUM_FIFOS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop_0,
  input  logic             pop_1,
  input  logic             pop_2,
  input  logic             pop_3,
  input  logic             empty_0,
  input  logic             empty_1,
  input  logic             empty_2,
  input  logic             empty_3,
  input  logic             idle,
  input  logic             req,
  input  logic [2:0]       idx,
  output logic [CNT_W-1:0] contador,
  output logic             valid
);

  import contador_palabras_pkg::*;

  logic [NUM_FIFOS-1:0] pops;
  logic [NUM_FIFOS-1:0] empties;
  logic [NUM_FIFOS-1:0] inc;
  logic [2:0]           inc_sum;
  logic [CNT_W-1:0]     cnt [NUM_FIFOS+1];
  logic [CNT_W-1:0]     sel;
  logic                 hit;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] contador_q, contador_d;
  logic             valid_q, valid_d;

  assign pops    = {pop_3, pop_2, pop_1, pop_0};
  assign empties = {empty_3, empty_2, empty_1, empty_0};

  // A pop on an empty FIFO moves no data, so it is not a word.
  assign inc = pops & ~empties;

  always_comb begin
    inc_sum = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      inc_sum = inc_sum + {2'b00, inc[i]};
    end
  end

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_fifo_cnt
    contador_unidad #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   ({2'b00, inc[g]}),
      .cnt   (cnt[g])
    );
  end

  contador_unidad #(
    .CNT_W (CNT_W)
  ) u_cnt_total (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_sum),
    .cnt   (cnt[NUM_FIFOS])
  );

  // Counter outputs are register values, so this returns the pre-increment count.
  always_comb begin
    sel = '0;
    for (int i = 0; i <= NUM_FIFOS; i++) begin
      if (idx == 3'(i)) begin
        sel = cnt[i];
      end
    end
  end

  assign hit = req & idle & (idx <= IDX_TOTAL);

  always_comb begin
    state_d    = state_q;
    contador_d = contador_q;
    valid_d    = 1'b0;
    unique case (state_q)
      COUNT: begin
        if (hit) begin
          state_d    = READ;
          contador_d = sel;
          valid_d    = 1'b1;
        end
      end
      READ: begin
        if (hit) begin
          contador_d = sel;
          valid_d    = 1'b1;
        end else begin
          state_d = COUNT;
        end
      end
      default: state_d = COUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COUNT;
      contador_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      contador_q <= contador_d;
      valid_q    <= valid_d;
    end
  end

  assign contador = contador_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_contador_palabras.sv
// Scoreboard bench for contador_palabras: directed plan followed by random traffic,
// checked against word totals kept as plain integers.
module tb_contador_palabras;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pop_0 = 1'b0, pop_1 = 1'b0, pop_2 = 1'b0, pop_3 = 1'b0;
  logic         empty_0 = 1'b0, empty_1 = 1'b0, empty_2 = 1'b0, empty_3 = 1'b0;
  logic         idle = 1'b0;
  logic         req = 1'b0;
  logic [2:0]   idx = 3'd0;
  logic [W-1:0] contador;
  logic         valid;

  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;
  bit           mon_en = 1'b0;

  // Words popped per FIFO since the last reset, unbounded.
  int unsigned  words [4];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_cont = '0;

  contador_palabras dut (
    .clk      (clk),
    .reset    (reset),
    .pop_0    (pop_0),
    .pop_1    (pop_1),
    .pop_2    (pop_2),
    .pop_3    (pop_3),
    .empty_0  (empty_0),
    .empty_1  (empty_1),
    .empty_2  (empty_2),
    .empty_3  (empty_3),
    .idle     (idle),
    .req      (req),
    .idx      (idx),
    .contador (contador),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_val(input logic [2:0] ix);
    int unsigned v;
    if (ix == 3'd4) v = words[0] + words[1] + words[2] + words[3];
    else            v = words[ix];
    return W'(v % 32);
  endfunction

  // One clock of stimulus; the expected response is queued once the edge has happened.
  task automatic step(input logic [3:0] p, input logic [3:0] e, input logic id,
                      input logic rq, input logic [2:0] ix, input logic rs);
    logic         hit;
    logic [W-1:0] ev;
    {pop_3, pop_2, pop_1, pop_0}         = p;
    {empty_3, empty_2, empty_1, empty_0} = e;
    idle  = id;
    req   = rq;
    idx   = ix;
    reset = rs;
    hit   = !rs && rq && id && (ix <= 3'd4);
    ev    = ref_val(ix);
    for (int i = 0; i < 4; i++) begin
      if (rs) words[i] = 0;
      else if (p[i] && !e[i]) words[i] = words[i] + 1;
    end
    @(posedge clk);
    if (hit) exp_q.push_back(ev);
    if (rs) last_cont = '0;
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic read(input logic [2:0] ix);
    step(4'h0, 4'h0, 1'b1, 1'b1, ix, 1'b0);
  endtask

  // Monitor: every falling edge checks valid against the queue and contador
  // against the last response (it must hold when no response is due).
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_valid;
      exp_valid = (exp_q.size() != 0);
      if (exp_valid) last_cont = exp_q.pop_front();
      n_checks++;
      if (valid !== exp_valid) begin
        n_fail++;
        $display("FAIL valid at %0t: got %b expected %b", $time, valid, exp_valid);
      end
      n_checks++;
      if (contador !== last_cont) begin
        n_fail++;
        $display("FAIL contador at %0t: got %0d expected %0d", $time, contador, last_cont);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) words[i] = 0;
    step(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
    mon_en = 1'b1;
    quiet(2);

    // Back-to-back reads of every counter after reset.
    for (int i = 0; i <= 4; i++) read(3'(i));
    quiet(2);

    // 3/2/1/0 words on FIFOs 0..3, then read all.
    step(4'b0111, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(4'b0011, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    step(4'b0001, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i <= 4; i++) read(3'(i));
    quiet(1);

    // Pops on an empty FIFO2 are not words.
    for (int i = 0; i < 4; i++) step(4'b0100, 4'b0100, 1'b1, 1'b0, 3'd0, 1'b0);
    read(3'd2);
    quiet(1);

    // 33 words on FIFO3 wraps its counter.
    for (int i = 0; i < 33; i++) step(4'b1000, 4'h0, 1'b1, 1'b0, 3'd0, 1'b0);
    read(3'd3);
    read(3'd4);
    quiet(1);

    // Request while busy is dropped; illegal index is ignored.
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 3'd1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b1, 3'd1, 1'b0);
    quiet(1);
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b1, 1'b1, 3'd6, 1'b0);
    quiet(1);

    // Read and pop of FIFO0 in the same cycle.
    step(4'b0001, 4'h0, 1'b1, 1'b1, 3'd0, 1'b0);
    read(3'd0);
    quiet(1);

    // Reset while a read is in flight.
    read(3'd4);
    step(4'b1111, 4'h0, 1'b1, 1'b1, 3'd4, 1'b1);
    for (int i = 0; i <= 4; i++) read(3'(i));
    quiet(1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, 3'($urandom), $urandom_range(0, 59) == 0);
    end
    quiet(3);

    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
